// File: rtl/multicore_pll_ctrl_pkg.sv
// Shared types and default constants for the multicore PLL lock controller.
// Optional status counter is enabled by defining MULTICORE_PLL_CTRL_STATUS_EN.
package multicore_pll_ctrl_pkg;

    // Controller states: pulse PLL reset, wait for lock, qualify lock, run, give up.
    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } pll_state_e;

    localparam int unsigned DEF_RST_PULSE_CYCLES    = 16;
    localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 65536;
    localparam int unsigned DEF_MAX_RETRIES         = 3;

    // One counter is shared by all timed states, so it is sized for the
    // longest interval; it never has to hold more than that interval minus one.
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/multicore_sync2.sv
// Two-flop synchronizer for a single level signal; both flops clear on reset.
module multicore_sync2 (
    input  logic clk,
    input  logic reset_n,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    // Capture the asynchronous level, then re-register to settle metastability.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value; blocking here would collapse the two stages.
        if (!reset_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/multicore_pll_lock_ctrl.sv
// PLL reset / lock qualification controller with retry and fault handling.
// Define MULTICORE_PLL_CTRL_STATUS_EN to build the saturating lock-loss counter;
// without it lock_loss_cnt_o is tied to zero.
module multicore_pll_lock_ctrl
    import multicore_pll_ctrl_pkg::*;
#(
    parameter int unsigned RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
    parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int unsigned MAX_RETRIES         = DEF_MAX_RETRIES
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               pll_locked_i,
    input  logic                               relock_req_i,
    output logic                               pll_rst_o,
    output logic                               sys_reset_n_o,
    output logic                               ready_o,
    output logic                               fault_o,
    output logic                               lost_lock_o,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt_o,
    output logic [7:0]                         lock_loss_cnt_o
);

    localparam int unsigned RETRY_W = $clog2(MAX_RETRIES + 1);
    localparam int unsigned CNT_W   = cnt_width(RST_PULSE_CYCLES, LOCK_STABLE_CYCLES,
                                                LOCK_TIMEOUT_CYCLES);

    localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TO_LAST     = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);

    pll_state_e         r_state;
    pll_state_e         w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [RETRY_W-1:0] r_retry;
    logic [RETRY_W-1:0] w_retry_nxt;
    logic [RETRY_W-1:0] w_retry_inc;
    logic               r_pll_rst;
    logic               r_sys_rst_n;
    logic               r_ready;
    logic               r_fault;
    logic               r_lost;
    logic               w_pll_rst_nxt;
    logic               w_sys_rst_n_nxt;
    logic               w_ready_nxt;
    logic               w_fault_nxt;
    logic               w_lost_nxt;
    logic               w_lock;

    multicore_sync2 u_lock_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_async (pll_locked_i),
        .o_sync  (w_lock)
    );

    assign w_retry_inc = r_retry + RETRY_W'(1);

    // Next state, shared counter and the output values of the state being entered.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_retry_nxt = r_retry;
        w_lost_nxt  = 1'b0;

        unique case (r_state)
            ST_RESET_PLL: begin
                if (r_cnt == RST_LAST) begin
                    w_state_nxt = ST_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_WAIT_LOCK: begin
                if (w_lock) begin
                    // The cycle that saw lock is the first of the stable run.
                    w_state_nxt = ST_STABLE;
                    w_cnt_nxt   = CNT_W'(1);
                end else if (r_cnt == TO_LAST) begin
                    w_retry_nxt = w_retry_inc;
                    w_cnt_nxt   = '0;
                    w_state_nxt = (w_retry_inc == RETRY_MAX) ? ST_FAULT : ST_RESET_PLL;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_STABLE: begin
                if (!w_lock) begin
                    w_state_nxt = ST_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if (r_cnt >= STABLE_LAST) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = '0;
                    w_retry_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_RUN: begin
                // Lock loss wins over a coincident relock request.
                if (!w_lock) begin
                    w_state_nxt = ST_RESET_PLL;
                    w_cnt_nxt   = '0;
                    w_lost_nxt  = 1'b1;
                end else if (relock_req_i) begin
                    w_state_nxt = ST_RESET_PLL;
                    w_cnt_nxt   = '0;
                end
            end
            ST_FAULT: begin
                if (relock_req_i) begin
                    w_state_nxt = ST_RESET_PLL;
                    w_cnt_nxt   = '0;
                    w_retry_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = ST_RESET_PLL;
                w_cnt_nxt   = '0;
            end
        endcase

        w_pll_rst_nxt   = (w_state_nxt == ST_RESET_PLL) || (w_state_nxt == ST_FAULT);
        w_sys_rst_n_nxt = (w_state_nxt == ST_RUN);
        w_ready_nxt     = (w_state_nxt == ST_RUN);
        w_fault_nxt     = (w_state_nxt == ST_FAULT);
    end

    // State, counters and registered outputs all update on the same edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= ST_RESET_PLL;
            r_cnt       <= '0;
            r_retry     <= '0;
            r_pll_rst   <= 1'b1;
            r_sys_rst_n <= 1'b0;
            r_ready     <= 1'b0;
            r_fault     <= 1'b0;
            r_lost      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_retry     <= w_retry_nxt;
            r_pll_rst   <= w_pll_rst_nxt;
            r_sys_rst_n <= w_sys_rst_n_nxt;
            r_ready     <= w_ready_nxt;
            r_fault     <= w_fault_nxt;
            r_lost      <= w_lost_nxt;
        end
    end

    assign pll_rst_o     = r_pll_rst;
    assign sys_reset_n_o = r_sys_rst_n;
    assign ready_o       = r_ready;
    assign fault_o       = r_fault;
    assign lost_lock_o   = r_lost;
    assign retry_cnt_o   = r_retry;

`ifdef MULTICORE_PLL_CTRL_STATUS_EN
    logic [7:0] r_loss_cnt;

    // Count lock-loss events alongside the pulse, holding at full scale.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_loss_cnt <= 8'd0;
        end else if (w_lost_nxt && (r_loss_cnt != 8'hFF)) begin
            r_loss_cnt <= r_loss_cnt + 8'd1;
        end
    end

    assign lock_loss_cnt_o = r_loss_cnt;
`else
    assign lock_loss_cnt_o = 8'd0;
`endif

endmodule

// File: doc/multicore_pll_lock_ctrl.md
MULTICORE_PLL_LOCK_CTRL -- requirements
Module: multicore_pll_lock_ctrl

Interface
REQ-001 The module SHALL have a single clock domain; reset is synchronous, active-low.
REQ-002 The module SHALL have parameter RST_PULSE_CYCLES, default 16: PLL reset pulse length in clk cycles, minimum 1.
REQ-003 The module SHALL have parameter LOCK_STABLE_CYCLES, default 1024: consecutive synced-lock cycles required before release.
REQ-004 The module SHALL have parameter LOCK_TIMEOUT_CYCLES, default 65536: maximum wait for lock per attempt.
REQ-005 The module SHALL have parameter MAX_RETRIES, default 3: failed attempts before FAULT, minimum 1.
REQ-006 clk  in  1  free-running reference-domain clock (same source as PLL refclk).
REQ-007 reset_n  in  1  synchronous active-low reset.
REQ-008 pll_locked_i  in  1  PLL locked flag, asynchronous to clk.
REQ-009 relock_req_i  in  1  single-cycle request to re-run the PLL sequence.
REQ-010 pll_rst_o  out  1  active-high reset to PLL rst input.
REQ-011 sys_reset_n_o  out  1  active-low reset for logic clocked by PLL outputs.
REQ-012 ready_o  out  1  high only in RUN.
REQ-013 fault_o  out  1  high only in FAULT.
REQ-014 lost_lock_o  out  1  one-cycle pulse on lock loss in RUN.
REQ-015 retry_cnt_o  out  clog2(MAX_RETRIES+1)  failed attempts since last success or relock.
REQ-016 lock_loss_cnt_o  out  8  saturating lock-loss event count (see Configuration).

Function
REQ-017 pll_locked_i SHALL pass through a 2-flop synchronizer; "lock" below means the synchronized value (2-cycle latency).
REQ-018 All outputs SHALL be registered; FSM states: RESET_PLL, WAIT_LOCK, STABLE, RUN, FAULT.
REQ-019 RESET_PLL: pll_rst_o=1 for exactly RST_PULSE_CYCLES cycles, then WAIT_LOCK with counter cleared.
REQ-020 WAIT_LOCK: lock=1 -> STABLE; counter reaching LOCK_TIMEOUT_CYCLES-1 with lock=0 -> retry_cnt+1, then RESET_PLL, or FAULT if new retry_cnt equals MAX_RETRIES.
REQ-021 STABLE: lock=0 on any cycle -> WAIT_LOCK with counter cleared, retry_cnt unchanged; LOCK_STABLE_CYCLES consecutive lock=1 cycles -> RUN.
REQ-022 Entering RUN: sys_reset_n_o=1, ready_o=1 and retry_cnt=0 SHALL be registered on the same clock edge.
REQ-023 RUN with lock=0: lost_lock_o pulses 1 cycle; sys_reset_n_o=0 and ready_o=0 on that cycle; next state RESET_PLL.
REQ-024 RUN with relock_req_i=1 and lock=1: RESET_PLL, no lost_lock_o pulse.
REQ-025 Simultaneous lock loss and relock_req_i in RUN SHALL be one lock-loss event (pulse, count once).
REQ-026 FAULT: pll_rst_o=1, sys_reset_n_o=0, fault_o=1; exit only on relock_req_i -> RESET_PLL, retry_cnt cleared.
REQ-027 relock_req_i in RESET_PLL, WAIT_LOCK or STABLE SHALL be ignored.
REQ-028 sys_reset_n_o SHALL be 0 in every state except RUN.

Reset
REQ-029 reset_n=0 SHALL force RESET_PLL, pll_rst_o=1, sys_reset_n_o=0, ready_o=0, fault_o=0, lost_lock_o=0, counters and synchronizer flops 0, lock_loss_cnt_o=0.
REQ-030 After reset_n rises, RESET_PLL SHALL run its full RST_PULSE_CYCLES; reset mid-sequence restarts from RESET_PLL.

Configuration
REQ-031 Macro MULTICORE_PLL_CTRL_STATUS_EN defined: lock_loss_cnt_o increments on each lost_lock_o pulse, saturating at 255.
REQ-032 Macro undefined: lock_loss_cnt_o tied to 0, counter logic absent; all other behaviour identical.

Structure
REQ-033 Package multicore_pll_ctrl_pkg SHALL hold the state enum typedef and the default parameter constants.
REQ-034 Sub-module multicore_sync2 SHALL implement the 2-flop synchronizer, reset to 0.

Verification (RST_PULSE_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2)
REQ-035 Reset released, lock raised 10 cycles later and held -> pll_rst_o high exactly 4 cycles; sys_reset_n_o and ready_o rise 8 cycles after synced lock; retry_cnt_o=0.
REQ-036 Lock glitches low 1 cycle at STABLE count 5 -> back to WAIT_LOCK; RUN reached only after a further 8 clean cycles.
REQ-037 Lock never asserted -> two 32-cycle timeouts; retry_cnt_o 1 then 2; fault_o=1; pll_rst_o=1; relock_req_i clears fault and restarts.
REQ-038 Lock dropped in RUN -> lost_lock_o one-cycle pulse, sys_reset_n_o=0 the same cycle, new 4-cycle pll_rst_o pulse; with macro, lock_loss_cnt_o=1.
REQ-039 relock_req_i and lock drop on the same RUN cycle -> single pulse, lock_loss_cnt_o +1 only; 300 losses with macro -> saturates at 255.
REQ-040 reset_n asserted during WAIT_LOCK -> all outputs return to reset values next edge; sequence restarts with full 4-cycle pulse.
